cpu_state_dumper: RTL
=====================

// Module: cpu_state_dumper
// PURPOSE
//  Hardware readout of Simple_Single_CPU architectural state: on request, freezes the CPU and
//  reads PC, R0..R(NUM_REGS-1) and data memory words 0..NUM_MEM-1 in that order.
//  Streams them as tagged words over a valid/ready port to an off-chip/debug sink.
//  Sits beside the CPU core on spare read ports of the register file and data memory.
// PARAMETERS
//  DATA_W    32  width of PC, register and memory words
//  NUM_REGS  32  register-file entries dumped (index width 5)
//  NUM_MEM   32  data-memory words dumped (word index, not byte address)
//  IDX_W     6   width of dout_idx_o; must satisfy 2**IDX_W >= max(NUM_REGS,NUM_MEM)
// PORTS
//  clk_i         in   1       clock; single clock domain
//  rst_i         in   1       asynchronous, active-high reset
//  dump_req_i    in   1       start dump (level sampled in IDLE only)
//  cpu_hold_o    out  1       freeze CPU (PC/RF/DM writes gated) while high
//  pc_i          in   DATA_W  current PC value
//  rf_addr_o     out  5       register-file debug read address
//  rf_data_i     in   DATA_W  register-file read data, valid 1 cycle after rf_addr_o
//  dm_addr_o     out  IDX_W   data-memory debug word address
//  dm_data_i     in   DATA_W  data-memory read data, valid 1 cycle after dm_addr_o
//  dout_o        out  DATA_W  streamed word
//  dout_tag_o    out  2       0=PC 1=REG 2=MEM 3=CSUM
//  dout_idx_o    out  IDX_W   register/memory index of word (0 for PC/CSUM)
//  dout_valid_o  out  1       word valid
//  dout_ready_i  in   1       sink accepts word when valid&ready at posedge
//  busy_o        out  1       dump in progress
//  done_o        out  1       one-cycle pulse after final word accepted
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; all outputs 0; index counter 0; checksum 0.
//  FSM: IDLE -> HOLD -> {ADDR -> CAPT -> SEND} per word -> DONE -> IDLE.
//   IDLE: dump_req_i=1 -> HOLD; busy_o, cpu_hold_o rise next cycle. Other requests ignored
//     while busy (no queueing).
//   HOLD: one cycle to let any in-flight CPU write retire; then SEND PC word (pc_i captured).
//   ADDR: drive rf_addr_o/dm_addr_o = idx. CAPT: load dout_o from rf_data_i/dm_data_i.
//   SEND: dout_valid_o=1; dout_o/tag/idx stable until handshake; on valid&ready advance:
//     PC -> REG idx0; REG idx NUM_REGS-1 -> MEM idx0; MEM idx NUM_MEM-1 -> DONE (or CSUM).
//   DONE: done_o=1 for one cycle; busy_o, cpu_hold_o drop; -> IDLE.
//  Throughput: 1 word per 3 cycles min (ADDR,CAPT,SEND with ready high); PC word 1 cycle after HOLD.
//  dout_ready_i low indefinitely: stall in SEND, hold continues, no data change.
//  Ready high outside SEND: ignored. Index counter wraps to 0 at each section boundary.
//  Total words: 1+NUM_REGS+NUM_MEM (65 default), +1 with checksum.
//  Reset mid-dump: abort immediately, cpu_hold_o=0, no done_o pulse.
// CONFIGURATION
//  DUMP_CHECKSUM_EN defined: XOR of every accepted word accumulated; after last MEM word,
//   extra SEND with tag=3, idx=0, dout_o=checksum; DONE after its handshake.
//  Not defined: no accumulator, tag 3 never emitted, DONE right after last MEM word.
// STRUCTURE
//  Shared package cpu_dbg_pkg: TAG_PC/TAG_REG/TAG_MEM/TAG_CSUM constants, FSM state
//   encodings, default DATA_W. Sub-module dump_out_stage: output holding register with
//   valid/ready (load, hold-while-stalled, clear on accept); FSM+counters stay in top.
// TESTING
//  Reset, pc_i=0x40, R5=7, DM[3]=9, req pulse, ready=1 -> 65 words: PC 0x40, REG idx5=7, MEM idx3=9; done_o once.
//  Ready toggled 1-of-4 cycles -> identical stream, dout_o stable whenever valid&!ready.
//  Second req during dump -> ignored; exactly 65 words, one done_o.
//  rst_i at word 20 -> all outputs 0 same cycle; new req restarts from PC word.
//  cpu_hold_o high from HOLD through DONE; CPU PC unchanged across dump, resumes after.
//  DUMP_CHECKSUM_EN, all regs/mem=1, PC=0 -> 66th word tag 3, value 0 (even count of 1s).

Source files
------------

// File: rtl/cpu_dbg_pkg.sv
// Shared debug-dump constants: stream tags, FSM encodings, default width.
// Optional checksum word is enabled by defining DUMP_CHECKSUM_EN.
package cpu_dbg_pkg;

  localparam int DATA_W_DEF = 32;

  typedef logic [1:0] tag_t;

  localparam tag_t TAG_PC   = 2'd0;
  localparam tag_t TAG_REG  = 2'd1;
  localparam tag_t TAG_MEM  = 2'd2;
  localparam tag_t TAG_CSUM = 2'd3;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HOLD = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_CAPT = 3'd3;
  localparam logic [2:0] S_SEND = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

endpackage

// File: rtl/cpu_state_dumper_if.sv
// Tagged dump stream: valid/ready word port from dumper to debug sink.
// Master drives the word, slave returns ready.
interface cpu_state_dumper_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 6
);
  logic [DATA_W-1:0] dout;
  logic [1:0]        dout_tag;
  logic [IDX_W-1:0]  dout_idx;
  logic              dout_valid;
  logic              dout_ready;

  modport master (
    output dout, dout_tag, dout_idx, dout_valid,
    input  dout_ready
  );

  modport slave (
    input  dout, dout_tag, dout_idx, dout_valid,
    output dout_ready
  );
endinterface

// File: rtl/dump_out_stage.sv
// Output holding register for the dump stream.
// Load wins over accept so a new word can follow an accept directly.
module dump_out_stage
  import cpu_dbg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  tag_t              tag_in,
  input  logic [IDX_W-1:0]  idx_in,
  input  logic              ready,
  output logic [DATA_W-1:0] dout,
  output tag_t              tag,
  output logic [IDX_W-1:0]  idx,
  output logic              valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout  <= '0;
      tag   <= TAG_PC;
      idx   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      dout  <= din;
      tag   <= tag_in;
      idx   <= idx_in;
      valid <= 1'b1;
    end else if (valid && ready) begin
      dout  <= '0;
      tag   <= TAG_PC;
      idx   <= '0;
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/cpu_state_dumper.sv
// Freezes the CPU and streams PC, register file and data memory as tagged words.
// Define DUMP_CHECKSUM_EN to append an XOR checksum word (tag 3).
module cpu_state_dumper
  import cpu_dbg_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = 32,
  parameter int NUM_MEM  = 32,
  parameter int IDX_W    = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              dump_req_i,
  output logic              cpu_hold_o,
  input  logic [DATA_W-1:0] pc_i,
  output logic [4:0]        rf_addr_o,
  input  logic [DATA_W-1:0] rf_data_i,
  output logic [IDX_W-1:0]  dm_addr_o,
  input  logic [DATA_W-1:0] dm_data_i,
  output logic              busy_o,
  output logic              done_o,
  cpu_state_dumper_if.master dout_if
);

  logic [2:0]        state;
  tag_t              sec;
  logic [IDX_W-1:0]  idx;
  logic              accept;
  logic              last_reg;
  logic              last_mem;
  logic              ld;
  logic [DATA_W-1:0] ld_data;
  tag_t              ld_tag;
  logic [IDX_W-1:0]  ld_idx;
`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum;
`endif

  assign accept   = (state == S_SEND) && dout_if.dout_valid
                    && dout_if.dout_ready;
  assign last_reg = (idx == IDX_W'(NUM_REGS - 1));
  assign last_mem = (idx == IDX_W'(NUM_MEM - 1));

  assign busy_o     = (state != S_IDLE);
  assign cpu_hold_o = (state != S_IDLE);
  assign done_o     = (state == S_DONE);
  assign rf_addr_o  = idx[4:0];
  assign dm_addr_o  = idx;

  always_comb begin
    ld      = 1'b0;
    ld_data = '0;
    ld_tag  = TAG_PC;
    ld_idx  = '0;
    unique case (1'b1)
      (state == S_HOLD): begin
        ld      = 1'b1;
        ld_data = pc_i;
      end
      (state == S_CAPT): begin
        ld      = 1'b1;
        ld_tag  = sec;
        ld_idx  = idx;
        ld_data = (sec == TAG_REG) ? rf_data_i : dm_data_i;
      end
`ifdef DUMP_CHECKSUM_EN
      // Checksum includes the MEM word being accepted this cycle.
      (accept && sec == TAG_MEM && last_mem): begin
        ld      = 1'b1;
        ld_tag  = TAG_CSUM;
        ld_data = csum ^ dout_if.dout;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      sec   <= TAG_PC;
      idx   <= '0;
`ifdef DUMP_CHECKSUM_EN
      csum  <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          sec  <= TAG_PC;
          idx  <= '0;
`ifdef DUMP_CHECKSUM_EN
          csum <= '0;
`endif
          if (dump_req_i) state <= S_HOLD;
        end
        S_HOLD: state <= S_SEND;
        S_ADDR: state <= S_CAPT;
        S_CAPT: state <= S_SEND;
        S_SEND: begin
          if (accept) begin
`ifdef DUMP_CHECKSUM_EN
            csum <= csum ^ dout_if.dout;
`endif
            unique case (sec)
              TAG_PC: begin
                sec   <= TAG_REG;
                idx   <= '0;
                state <= S_ADDR;
              end
              TAG_REG: begin
                if (last_reg) begin
                  sec <= TAG_MEM;
                  idx <= '0;
                end else begin
                  idx <= idx + 1'b1;
                end
                state <= S_ADDR;
              end
              TAG_MEM: begin
                if (last_mem) begin
                  idx <= '0;
`ifdef DUMP_CHECKSUM_EN
                  sec   <= TAG_CSUM;
                  state <= S_SEND;
`else
                  state <= S_DONE;
`endif
                end else begin
                  idx   <= idx + 1'b1;
                  state <= S_ADDR;
                end
              end
              default: state <= S_DONE;
            endcase
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  dump_out_stage #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_out (
    .clk    (clk_i),
    .rst    (rst_i),
    .load   (ld),
    .din    (ld_data),
    .tag_in (ld_tag),
    .idx_in (ld_idx),
    .ready  (dout_if.dout_ready),
    .dout   (dout_if.dout),
    .tag    (dout_if.dout_tag),
    .idx    (dout_if.dout_idx),
    .valid  (dout_if.dout_valid)
  );

endmodule
